// File: rtl/eject2x2.sv
// eject2x2: two-lane ring ejection stage; flits addressed to NODE_ID are queued
// per lane for local sinks, everything else passes through (or deflects when full).
module eject2x2 #(
    parameter int NODE_ID    = 0,
    parameter int DST_LSB    = 4,
    parameter int DST_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [143:0] port0_ci,
    input  logic [143:0] port1_ci,
    input  logic         portl0_ri,
    input  logic         portl1_ri,
    output logic [143:0] port0_co,
    output logic [143:0] port1_co,
    output logic [143:0] portl0_co,
    output logic [143:0] portl1_co,
    output logic [3:0]   l0_cnt,
    output logic [3:0]   l1_cnt,
    output logic [15:0]  defl_cnt
);
    localparam int CW = 144;
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CW-1:0] w_ci  [2];
    logic [CW-1:0] w_co  [2];
    logic [CW-1:0] w_lo  [2];
    logic [3:0]    w_cnt [2];
    logic [1:0]    w_ri;
    logic [1:0]    w_defl;
    logic [16:0]   w_dsum;
    logic [15:0]   r_defl;

    assign w_ci[0]   = port0_ci;
    assign w_ci[1]   = port1_ci;
    assign w_ri      = {portl1_ri, portl0_ri};
    assign port0_co  = w_co[0];
    assign port1_co  = w_co[1];
    assign portl0_co = w_lo[0];
    assign portl1_co = w_lo[1];
    assign l0_cnt    = w_cnt[0];
    assign l1_cnt    = w_cnt[1];
    assign defl_cnt  = r_defl;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [CW-1:0] r_mem [FIFO_DEPTH];
        logic [CW-1:0] r_co;
        logic [3:0]    r_cnt;
        logic [PW-1:0] r_wp, r_rp;
        logic          w_match, w_pop, w_push;

        assign w_match   = w_ci[g][0] && (w_ci[g][DST_LSB +: DST_W] == DST_W'(NODE_ID));
        assign w_pop     = (r_cnt != 4'd0) && w_ri[g];
        // A full FIFO still accepts when its head leaves in the same cycle
        assign w_push    = w_match && ((r_cnt < 4'(FIFO_DEPTH)) || w_pop);
        assign w_defl[g] = w_match && !w_push;
        assign w_co[g]   = r_co;
        assign w_cnt[g]  = r_cnt;
        assign w_lo[g]   = (r_cnt != 4'd0) ? r_mem[r_rp] : '0;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_co  <= '0;
                r_cnt <= '0;
                r_wp  <= '0;
                r_rp  <= '0;
            end else begin
                r_co  <= (w_ci[g][0] && !w_push) ? w_ci[g] : '0;
                r_cnt <= r_cnt + 4'(w_push) - 4'(w_pop);
                if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
                if (w_pop) r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wp] <= w_ci[g];
        end
    end

    assign w_dsum = {1'b0, r_defl} + 17'(w_defl[0]) + 17'(w_defl[1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_defl <= '0;
        else r_defl <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
    end
endmodule

// File: tb/tb_eject2x2.sv
// tb_eject2x2: directed + random checks of eject2x2 against a queue-based model.
module tb_eject2x2;
    localparam logic [127:0] UP = 128'h0123456789abcdef0123456789abcdef;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [143:0] p0ci = '0, p1ci = '0;
    logic         r0 = 1'b0, r1 = 1'b0;
    logic [143:0] p0co, p1co, pl0co, pl1co;
    logic [3:0]   c0, c1;
    logic [15:0]  dc;

    int checks = 0;
    int errors = 0;
    logic [143:0] q0[$], q1[$];
    int unsigned  dmodel = 0;
    logic [143:0] e0 = '0, e1 = '0;

    eject2x2 #(.NODE_ID(5), .DST_LSB(4), .DST_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .port0_ci(p0ci), .port1_ci(p1ci),
        .portl0_ri(r0), .portl1_ri(r1),
        .port0_co(p0co), .port1_co(p1co),
        .portl0_co(pl0co), .portl1_co(pl1co),
        .l0_cnt(c0), .l1_cnt(c1), .defl_cnt(dc)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] fl(input logic [15:0] lo);
        return {UP, lo};
    endfunction

    function automatic logic match(input logic [143:0] f);
        return f[0] && (f[7:4] == 4'd5);
    endfunction

    task automatic chk(input string tag, input logic [143:0] o, input logic [143:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, o, e);
        end
    endtask

    task automatic check_all();
        chk("port0_co", p0co, e0);
        chk("port1_co", p1co, e1);
        chk("portl0_co", pl0co, q0.size() > 0 ? q0[0] : 144'd0);
        chk("portl1_co", pl1co, q1.size() > 0 ? q1[0] : 144'd0);
        chk("l0_cnt", 144'(c0), 144'(q0.size()));
        chk("l1_cnt", 144'(c1), 144'(q1.size()));
        chk("defl_cnt", 144'(dc), 144'(dmodel));
    endtask

    task automatic step(input logic [143:0] a, input logic [143:0] b, input logic ra, input logic rb);
        logic pop0, pop1, push0, push1;
        p0ci = a; p1ci = b; r0 = ra; r1 = rb;
        pop0  = (q0.size() > 0) && ra;
        pop1  = (q1.size() > 0) && rb;
        push0 = match(a) && (q0.size() < 4 || pop0);
        push1 = match(b) && (q1.size() < 4 || pop1);
        e0 = (a[0] && !push0) ? a : 144'd0;
        e1 = (b[0] && !push1) ? b : 144'd0;
        dmodel += 32'(match(a) && !push0) + 32'(match(b) && !push1);
        if (dmodel > 32'hFFFF) dmodel = 32'hFFFF;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (push0) q0.push_back(a);
        if (push1) q1.push_back(b);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [143:0] rnd_flit();
        logic [15:0] lo;
        logic [127:0] up;
        lo = 16'($urandom);
        up = UP ^ {4{$urandom}};
        if ($urandom_range(0, 1) == 1) lo[7:4] = 4'd5;
        return {up, lo};
    endfunction

    initial begin
        #23;
        e0 = '0; e1 = '0;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        step(fl(16'h1861), '0, 1'b0, 1'b0);
        step('0, fl(16'h1851), 1'b0, 1'b0);
        step(fl(16'h1850), '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(fl(16'h1851 + 16'(i << 8)), '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(fl(16'h2851 + 16'(i << 12)), '0, 1'b0, 1'b0);
        step(fl(16'h3851), '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++)
            step(rnd_flit(), rnd_flit(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step('0, fl(16'h1851 + 16'(i << 8)), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        q0.delete(); q1.delete(); dmodel = 0; e0 = '0; e1 = '0;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        step('0, fl(16'h1851), 1'b0, 1'b0);
        chk("l1_cnt_after_reset", 144'(c1), 144'd1);
        for (int i = 0; i < 4; i++) step(fl(16'h1851), fl(16'h1851), 1'b0, 1'b0);
        for (int i = 0; i < 32800; i++) step(fl(16'h1851), fl(16'h1851), 1'b0, 1'b0);
        chk("defl_sat", 144'(dc), 144'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eject2x2.md
EJECT2X2 -- requirements
Module: eject2x2

Interface
REQ-001 Parameter NODE_ID, default 0: ring address of this node; flits whose destination equals it are ejected.
REQ-002 Parameter DST_LSB, default 4: bit position of the destination field LSB in a flit.
REQ-003 Parameter DST_W, default 4: destination field width in bits.
REQ-004 Parameter FIFO_DEPTH, default 4, legal values 2..8: entries per ejection FIFO.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 port0_ci  input  144 (`control_w)  ring lane 0 flit in; bit 0 is the valid bit.
REQ-008 port1_ci  input  144 (`control_w)  ring lane 1 flit in; bit 0 is the valid bit.
REQ-009 portl0_ri  input  1  local sink 0 ready.
REQ-010 portl1_ri  input  1  local sink 1 ready.
REQ-011 port0_co  output  144  registered ring lane 0 flit out, pass-through or deflected.
REQ-012 port1_co  output  144  registered ring lane 1 flit out.
REQ-013 portl0_co  output  144  head of ejection FIFO 0; all zeros when FIFO 0 is empty.
REQ-014 portl1_co  output  144  head of ejection FIFO 1; all zeros when FIFO 1 is empty.
REQ-015 l0_cnt, l1_cnt  output  4 each  occupancy of ejection FIFO 0 / FIFO 1.
REQ-016 defl_cnt  output  16  saturating count of deflected flits.

Function
REQ-017 A flit on lane N (N = 0 or 1) matches when bit 0 = 1 and bits [DST_LSB+DST_W-1:DST_LSB] = NODE_ID.
REQ-018 Lane N feeds FIFO N only; port0 and port1 lanes are independent and never cross.
REQ-019 A matching flit is written to FIFO N when lN_cnt < FIFO_DEPTH, or when lN_cnt = FIFO_DEPTH and a pop of FIFO N occurs in the same cycle.
REQ-020 An ejected flit drives port N_co to all zeros on the next cycle.
REQ-021 A matching flit that REQ-019 rejects (FIFO full, no pop) is deflected: it appears unmodified on portN_co on the next cycle, and defl_cnt increments.
REQ-022 A valid non-matching flit appears unmodified on portN_co on the next cycle (1-cycle latency).
REQ-023 An invalid input (bit 0 = 0) drives portN_co to all zeros on the next cycle, whatever the upper bits hold.
REQ-024 portlN_co shows the FIFO N head combinationally from registered state, with bit 0 = 1 whenever the FIFO is non-empty.
REQ-025 A pop of FIFO N occurs at a rising edge when lN_cnt > 0 and portlN_ri = 1; portlN_ri is ignored while empty.
REQ-026 A simultaneous push and pop leaves lN_cnt unchanged and preserves FIFO order.
REQ-027 A push into an empty FIFO is visible on portlN_co one cycle after the input edge; no fall-through.
REQ-028 FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 defl_cnt saturates at 16'hFFFF; two deflections in one cycle add 2, clamped to 16'hFFFF.

Reset
REQ-030 While rst = 0, all outputs SHALL be zero: port0_co, port1_co, portl0_co, portl1_co, l0_cnt, l1_cnt and defl_cnt.
REQ-031 Assertion of rst empties both FIFOs, clears pointers and counters, and discards in-flight flits, asynchronously and regardless of clk.
REQ-032 On the first rising edge after rst deasserts, inputs are sampled normally.

Verification (NODE_ID=5, DST_LSB=4, DST_W=4, FIFO_DEPTH=4; flits shown by low 16 bits, upper 128 bits = 0123456789abcdef0123456789abcdef)
REQ-033 port0_ci=…1861, one edge -> port0_co=…1861, portl0_co=0, l0_cnt=0.
REQ-034 port1_ci=…1851, portl1_ri=0, one edge -> port1_co=0, portl1_co=…1851, l1_cnt=1.
REQ-035 port0_ci=…1850 (invalid, dest 5), one edge -> port0_co=0, l0_cnt=0.
REQ-036 Five consecutive …1851 flits on lane 0, portl0_ri=0 -> l0_cnt=4, the 5th flit appears on port0_co, defl_cnt=1; then portl0_ri=1 for four edges -> the four flits pop in order and l0_cnt=0.
REQ-037 FIFO 0 full; matching flit with portl0_ri=1 in the same cycle -> flit accepted, l0_cnt stays 4, defl_cnt unchanged.
REQ-038 rst pulled low mid-stream with l1_cnt=3, between clock edges -> all outputs 0 immediately; after release, the first …1851 flit on lane 1 gives l1_cnt=1.
